// File: rtl/lsu_pkg.sv
// Shared types and constants for the AXI4-Lite load/store master.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Stores only know B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
    if (write) return f3 > F3_W;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replication and load extraction/extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'b1111;
    wdata = st_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = lane[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_raw;
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/axi_lite_lsu_master.sv
// Single-outstanding RV32 load/store unit bridging to AXI4-Lite.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them.
module axi_lite_lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  lsu_state_e        state;
  logic              write_q;
  logic              err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] req_addr_al;
  logic              req_mis;
  logic              acc_err;
  logic [2:0]        la_f3;
  logic [1:0]        la_lane;
  logic [3:0]        st_wstrb;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_addr_al = req_addr;
  always_comb begin
    case (req_funct3[1:0])
      2'b01:   req_mis = req_addr[0];
      2'b10:   req_mis = (req_addr[1:0] != 2'b00);
      default: req_mis = 1'b0;
    endcase
  end
`else
  always_comb begin
    req_addr_al = req_addr;
    case (req_funct3[1:0])
      2'b01:   req_addr_al[0]   = 1'b0;
      2'b10:   req_addr_al[1:0] = 2'b00;
      default: ;
    endcase
  end
  assign req_mis = 1'b0;
`endif

  assign acc_err = f3_illegal(req_write, req_funct3) || req_mis;

  // Store lanes are resolved at acceptance, load lanes on the R beat.
  assign la_f3   = (state == ST_IDLE) ? req_funct3 : f3_q;
  assign la_lane = (state == ST_IDLE) ? req_addr_al[1:0] : addr_q[1:0];

  lsu_lane_align u_lane_align (
    .funct3  (la_f3),
    .lane    (la_lane),
    .st_data (req_wdata),
    .ld_raw  (rdata),
    .wstrb   (st_wstrb),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

  assign awaddr = addr_q;
  assign araddr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wdata     <= 32'd0;
      wstrb     <= 4'd0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            f3_q      <= req_funct3;
            addr_q    <= req_addr_al;
            err_q     <= acc_err;
            wdata     <= st_wdata;
            wstrb     <= st_wstrb;
            if (!acc_err) begin
              if (req_write) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
              end else begin
                arvalid <= 1'b1;
              end
            end
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (err_q) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
            state     <= ST_DONE;
          end else if (write_q) begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
            if ((!awvalid || awready) && (!wvalid || wready)) begin
              bready <= 1'b1;
              state  <= ST_RESP;
            end
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (write_q) begin
            if (bvalid) begin
              bready    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= (bresp & RESP_SLVERR) != RESP_OKAY;
              rsp_rdata <= 32'd0;
              state     <= ST_DONE;
            end
          end else if (rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= (rresp & RESP_SLVERR) != RESP_OKAY;
            rsp_rdata <= ld_data;
            state     <= ST_DONE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_lsu_master.sv
// Self-checking bench for axi_lite_lsu_master with a reactive AXI-Lite slave and behavioural reference model.
module tb_axi_lite_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_lite_lsu_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_txn(
    input string tag, input bit wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
    input logic [1:0] resp, input logic [31:0] rd,
    output logic [31:0] o_rdata, output logic o_err, output logic [31:0] o_addr,
    output logic [3:0] o_strb, output logic [31:0] o_wdata);
    bit illegal, mis, errp, eerr;
    int sz, lane, elat, k, cyc, n_rsp, rsp_cyc;
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit aw_done, w_done, ar_done, b_done, r_done, aw_pend, w_pend, ar_pend;
    bit traffic, stab_bad;
    logic [31:0] eaddr, ewd, erd, ext, bt, hw;
    logic [3:0] estrb;

    // reference model
    sz = int'(f3[1:0]);
    illegal = wr ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    errp  = illegal || mis;
    eaddr = addr;
`else
    errp  = illegal;
    eaddr = (sz == 2) ? (addr & ~32'd3) : (sz == 1) ? (addr & ~32'd1) : addr;
`endif
    lane = int'(eaddr % 4);
    estrb = (sz == 0) ? (4'b0001 << lane) : (sz == 1) ? (4'b0011 << lane) : 4'hF;
    ewd = (sz == 0) ? {4{wd[7:0]}} : (sz == 1) ? {2{wd[15:0]}} : wd;
    bt = (rd >> (8 * lane)) & 32'hFF;
    hw = (rd >> (8 * lane)) & 32'hFFFF;
    case (f3)
      3'd0: ext = bt[7] ? (bt | 32'hFFFFFF00) : bt;
      3'd1: ext = hw[15] ? (hw | 32'hFFFF0000) : hw;
      3'd2: ext = rd;
      3'd4: ext = bt;
      3'd5: ext = hw;
      default: ext = 32'd0;
    endcase
    erd  = (errp || wr) ? 32'd0 : ext;
    eerr = errp ? 1'b1 : resp[1];
    elat = errp ? 2 : wr ? (3 + ((aw_d > w_d) ? aw_d : w_d) + b_d) : (3 + ar_d + r_d);

    o_rdata = 'x; o_err = 1'bx; o_addr = 'x; o_strb = 'x; o_wdata = 'x;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; traffic = 0; stab_bad = 0;
    n_rsp = 0; rsp_cyc = -1;

    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL %s req_ready_wait got 0 want 1", tag);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc;
          o_rdata = rsp_rdata;
          o_err = rsp_err;
        end
      end
      if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid)) stab_bad = 1;
      if ((aw_done && awvalid) || (w_done && wvalid) || (ar_done && arvalid)) stab_bad = 1;
      if (awvalid || wvalid || arvalid) traffic = 1;
      // B and R use handshake state from earlier cycles only
      bvalid = 1'b0;
      if (wr && aw_done && w_done && !b_done) begin
        if (b_wait >= b_d) begin
          bvalid = 1'b1; bresp = resp;
          if (bready) b_done = 1;
        end else b_wait++;
      end
      rvalid = 1'b0;
      if (!wr && ar_done && !r_done) begin
        if (r_wait >= r_d) begin
          rvalid = 1'b1; rresp = resp; rdata = rd;
          if (rready) r_done = 1;
        end else r_wait++;
      end
      awready = 1'b0;
      if (awvalid && !aw_done) begin
        if (aw_wait >= aw_d) begin awready = 1'b1; aw_done = 1; o_addr = awaddr; end
        else aw_wait++;
      end
      wready = 1'b0;
      if (wvalid && !w_done) begin
        if (w_wait >= w_d) begin wready = 1'b1; w_done = 1; o_wdata = wdata; o_strb = wstrb; end
        else w_wait++;
      end
      arready = 1'b0;
      if (arvalid && !ar_done) begin
        if (ar_wait >= ar_d) begin arready = 1'b1; ar_done = 1; o_addr = araddr; end
        else ar_wait++;
      end
      aw_pend = awvalid && !awready;
      w_pend  = wvalid && !wready;
      ar_pend = arvalid && !arready;
      if (rsp_cyc >= 0 && cyc >= rsp_cyc + 2) break;
      if (cyc >= 80) break;
    end
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;

    n_cmp++;
    if (n_rsp !== 1) begin n_fail++; $display("FAIL %s rsp_valid_count got %0d want 1", tag, n_rsp); end
    if (n_rsp > 0) begin
      n_cmp++;
      if (rsp_cyc !== elat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", tag, rsp_cyc, elat); end
      n_cmp++;
      if (o_rdata !== erd) begin n_fail++; $display("FAIL %s rsp_rdata got %h want %h", tag, o_rdata, erd); end
      n_cmp++;
      if (o_err !== eerr) begin n_fail++; $display("FAIL %s rsp_err got %b want %b", tag, o_err, eerr); end
      n_cmp++;
      if (rsp_rdata !== erd || rsp_err !== eerr) begin
        n_fail++; $display("FAIL %s rsp_hold got %h/%b want %h/%b", tag, rsp_rdata, rsp_err, erd, eerr);
      end
    end
    if (errp) begin
      n_cmp++;
      if (traffic !== 1'b0) begin n_fail++; $display("FAIL %s axi_traffic got 1 want 0", tag); end
    end else if (wr) begin
      n_cmp++;
      if (o_addr !== eaddr) begin n_fail++; $display("FAIL %s awaddr got %h want %h", tag, o_addr, eaddr); end
      n_cmp++;
      if (o_strb !== estrb) begin n_fail++; $display("FAIL %s wstrb got %b want %b", tag, o_strb, estrb); end
      n_cmp++;
      if (o_wdata !== ewd) begin n_fail++; $display("FAIL %s wdata got %h want %h", tag, o_wdata, ewd); end
    end else begin
      n_cmp++;
      if (o_addr !== eaddr) begin n_fail++; $display("FAIL %s araddr got %h want %h", tag, o_addr, eaddr); end
    end
    n_cmp++;
    if (stab_bad !== 1'b0) begin n_fail++; $display("FAIL %s valid_stability got 1 want 0", tag); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, req_ready} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, req_ready});
    end
    n_cmp++;
    if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] rd_o, a_o, wd_o;
    logic e_o;
    logic [3:0] s_o;
    run_txn("sb_1003", 1, 3'b000, 32'h1003, 32'h000000AB, 0, 0, 0, 0, 0, 2'b00, 32'd0, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (a_o !== 32'h1003 || s_o !== 4'b1000 || wd_o !== 32'hABABABAB || e_o !== 1'b0) begin
      n_fail++; $display("FAIL sb_1003_fixed got %h %b %h %b want 00001003 1000 abababab 0", a_o, s_o, wd_o, e_o);
    end
    run_txn("lb_1002", 0, 3'b000, 32'h1002, 32'd0, 0, 0, 0, 1, 2, 2'b00, 32'h12803456, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (rd_o !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_1002_fixed got %h want ffffff80", rd_o); end
    run_txn("lbu_1002", 0, 3'b100, 32'h1002, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h12803456, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (rd_o !== 32'h00000080) begin n_fail++; $display("FAIL lbu_1002_fixed got %h want 00000080", rd_o); end
    run_txn("lhu_1002", 0, 3'b101, 32'h1002, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h12803456, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (rd_o !== 32'h00001280) begin n_fail++; $display("FAIL lhu_1002_fixed got %h want 00001280", rd_o); end
    run_txn("sw_wready_late", 1, 3'b010, 32'h2000, 32'hCAFEF00D, 0, 3, 1, 0, 0, 2'b00, 32'd0, rd_o, e_o, a_o, s_o, wd_o);
    run_txn("sw_slverr", 1, 3'b010, 32'h2004, 32'h11223344, 1, 0, 0, 0, 0, 2'b10, 32'd0, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (e_o !== 1'b1) begin n_fail++; $display("FAIL sw_slverr_fixed got %b want 1", e_o); end
    run_txn("lw_okay", 0, 3'b010, 32'h2008, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h89ABCDEF, rd_o, e_o, a_o, s_o, wd_o);
    n_cmp++;
    if (rd_o !== 32'h89ABCDEF || e_o !== 1'b0) begin
      n_fail++; $display("FAIL lw_okay_fixed got %h/%b want 89abcdef/0", rd_o, e_o);
    end
    run_txn("lw_1002", 0, 3'b010, 32'h1002, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h55667788, rd_o, e_o, a_o, s_o, wd_o);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (e_o !== 1'b1) begin n_fail++; $display("FAIL lw_1002_trap got %b want 1", e_o); end
`else
    n_cmp++;
    if (a_o !== 32'h1000) begin n_fail++; $display("FAIL lw_1002_align got %h want 00001000", a_o); end
`endif
    run_txn("sb_illegal_f3", 1, 3'b011, 32'h3000, 32'h1, 0, 0, 0, 0, 0, 2'b00, 32'd0, rd_o, e_o, a_o, s_o, wd_o);
    run_txn("ld_illegal_f3", 0, 3'b110, 32'h3000, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'd0, rd_o, e_o, a_o, s_o, wd_o);
  endtask

  task automatic test_random();
    logic [31:0] rd_o, a_o, wd_o;
    logic e_o;
    logic [3:0] s_o;
    for (int i = 0; i < 60; i++) begin
      run_txn("random", bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom, rd_o, e_o, a_o, s_o, wd_o);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4000; req_wdata = 32'h0BADBEEF;
    awready = 1'b0; wready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    n_cmp++;
    if (awvalid !== 1'b0 || wvalid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup got aw=%b w=%b want aw=0 w=1", awvalid, wvalid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, req_ready, rsp_valid} !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_drop got %b want 00000", {awvalid, wvalid, bready, req_ready, rsp_valid});
    end
    saw_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || awvalid || wvalid) saw_rsp = 1;
    end
    n_cmp++;
    if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_directed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
